// File: rtl/cpu_pkg.sv
// Shared types and constants for the Program 2 fixed-point divide engine.
package cpu_pkg;

    localparam int unsigned DM_DEPTH_DEF = 256;
    localparam int unsigned RF_DEPTH_DEF = 8;
    localparam int unsigned QBITS_DEF    = 24;
    localparam int unsigned DM_AW        = 8;

    typedef enum logic [3:0] {
        IDLE,
        LD0,
        LD1,
        LD2,
        DIV,
        ZERO,
        ST4,
        ST5,
        ST6,
        DONE
    } state_t;

    localparam logic [DM_AW-1:0] ADDR_DVD_HI = 8'd0;
    localparam logic [DM_AW-1:0] ADDR_DVD_LO = 8'd1;
    localparam logic [DM_AW-1:0] ADDR_DVS    = 8'd2;
    localparam logic [DM_AW-1:0] ADDR_Q2     = 8'd4;
    localparam logic [DM_AW-1:0] ADDR_Q1     = 8'd5;
    localparam logic [DM_AW-1:0] ADDR_Q0     = 8'd6;

    // R0..R2 hold the numerator on entry and the quotient on exit.
    localparam int unsigned R_Q2  = 0;
    localparam int unsigned R_Q1  = 1;
    localparam int unsigned R_Q0  = 2;
    localparam int unsigned R_REM = 3;
    localparam int unsigned R_DVS = 4;
    localparam int unsigned R_CNT = 5;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: asynchronous read, synchronous write, no reset.
module data_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH_DEF,
    parameter int unsigned AW    = DM_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] Core [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            Core[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = Core[addr_i];

endmodule

// File: rtl/reg_file.sv
// 8-bit register file: one masked write port covering all entries, async reads.
module reg_file
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = RF_DEPTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DEPTH-1:0]      we_i,
    input  logic [DEPTH-1:0][7:0] wdata_i,
    output logic [DEPTH-1:0][7:0] rdata_o
);

    logic [7:0] Registers [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                Registers[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (we_i[i]) begin
                    Registers[i] <= wdata_i[i];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdata_o[i] = Registers[i];
        end
    end

endmodule

// File: rtl/cpu.sv
// Program 2 engine: hardwired sequencer driving a restoring 16.8 / 8 divider
// through the register file, operands and quotient held in data memory.
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned DM_DEPTH = DM_DEPTH_DEF,
    parameter int unsigned RF_DEPTH = RF_DEPTH_DEF,
    parameter int unsigned QBITS    = QBITS_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);

    state_t state_q, state_d;
    logic   armed_q;

    logic                     dm_we;
    logic [DM_AW-1:0]         dm_addr;
    logic [7:0]               dm_wdata;
    logic [7:0]               dm_rdata;
    logic [RF_DEPTH-1:0]      rf_we;
    logic [RF_DEPTH-1:0][7:0] rf_wd;
    logic [RF_DEPTH-1:0][7:0] rf_rd;

    logic [8:0]  rem;
    logic        take;
    logic [23:0] shifted;

    data_mem #(
        .DEPTH (DM_DEPTH),
        .AW    (DM_AW)
    ) DM1 (
        .clk_i   (Clk),
        .we_i    (dm_we),
        .addr_i  (dm_addr),
        .wdata_i (dm_wdata),
        .rdata_o (dm_rdata)
    );

    reg_file #(
        .DEPTH (RF_DEPTH)
    ) RF1 (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (rf_we),
        .wdata_i (rf_wd),
        .rdata_o (rf_rd)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= Start;
        end
    end

    always_comb begin
        state_d  = state_q;
        dm_we    = 1'b0;
        dm_addr  = ADDR_DVS;
        dm_wdata = '0;
        rf_we    = '0;
        rf_wd    = rf_rd;

        // Next numerator bit comes off the top of R0; subtract result fits 8 bits.
        rem     = {rf_rd[R_REM], rf_rd[R_Q2][7]};
        take    = (rem >= {1'b0, rf_rd[R_DVS]});
        shifted = {rf_rd[R_Q2][6:0], rf_rd[R_Q1], rf_rd[R_Q0], take};

        unique case (state_q)
            IDLE: begin
                if (armed_q) state_d = LD0;
            end
            LD0: begin
                dm_addr       = ADDR_DVD_HI;
                rf_we[R_Q2]   = 1'b1;
                rf_wd[R_Q2]   = dm_rdata;
                state_d       = LD1;
            end
            LD1: begin
                dm_addr       = ADDR_DVD_LO;
                rf_we[R_Q1]   = 1'b1;
                rf_wd[R_Q1]   = dm_rdata;
                state_d       = LD2;
            end
            LD2: begin
                // R2 is the fractional numerator byte, so it must start at zero.
                dm_addr       = ADDR_DVS;
                rf_we[R_DVS]  = 1'b1;
                rf_wd[R_DVS]  = dm_rdata;
                rf_we[R_REM]  = 1'b1;
                rf_wd[R_REM]  = '0;
                rf_we[R_CNT]  = 1'b1;
                rf_wd[R_CNT]  = 8'(QBITS);
                rf_we[R_Q0]   = 1'b1;
                rf_wd[R_Q0]   = '0;
                state_d       = (dm_rdata == 8'd0) ? ZERO : DIV;
            end
            DIV: begin
                rf_we[R_REM]  = 1'b1;
                rf_wd[R_REM]  = take ? (rem[7:0] - rf_rd[R_DVS]) : rem[7:0];
                rf_we[R_Q2]   = 1'b1;
                rf_we[R_Q1]   = 1'b1;
                rf_we[R_Q0]   = 1'b1;
                rf_wd[R_Q2]   = shifted[23:16];
                rf_wd[R_Q1]   = shifted[15:8];
                rf_wd[R_Q0]   = shifted[7:0];
                rf_we[R_CNT]  = 1'b1;
                rf_wd[R_CNT]  = rf_rd[R_CNT] - 8'd1;
                if (rf_rd[R_CNT] == 8'd1) state_d = ST4;
            end
            ZERO: begin
                rf_we[R_Q2]   = 1'b1;
                rf_we[R_Q1]   = 1'b1;
                rf_we[R_Q0]   = 1'b1;
                rf_wd[R_Q2]   = '1;
                rf_wd[R_Q1]   = '1;
                rf_wd[R_Q0]   = '1;
                state_d       = ST4;
            end
            ST4: begin
                dm_we    = 1'b1;
                dm_addr  = ADDR_Q2;
                dm_wdata = rf_rd[R_Q2];
                state_d  = ST5;
            end
            ST5: begin
                dm_we    = 1'b1;
                dm_addr  = ADDR_Q1;
                dm_wdata = rf_rd[R_Q1];
                state_d  = ST6;
            end
            ST6: begin
                dm_we    = 1'b1;
                dm_addr  = ADDR_Q0;
                dm_wdata = rf_rd[R_Q0];
                state_d  = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (Start || Reset) begin
            state_d = IDLE;
            dm_we   = 1'b0;
            rf_we   = '0;
        end
    end

    assign Ack = (state_q == DONE);

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for the cpu fixed-point divide engine.
module tb_cpu;
    import cpu_pkg::*;

    logic Clk;
    logic Reset;
    logic Start;
    logic Ack;

    int checks;
    int errors;

    cpu dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Ack   (Ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic arm_and_load(input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge Clk);
        Start = 1'b1;
        dut.DM1.Core[0] = dvd[15:8];
        dut.DM1.Core[1] = dvd[7:0];
        dut.DM1.Core[2] = dvs;
        @(negedge Clk);
        checks++;
        if (Ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_while_start: got %b want 0", Ack);
        end
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic [23:0] expq, input int explat, input string name);
        int cyc;
        logic [23:0] q;
        arm_and_load(dvd, dvs);
        cyc = 0;
        while (Ack !== 1'b1 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
        end
        checks++;
        if (cyc - 1 != explat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc - 1, explat);
        end
        q = {dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]};
        checks++;
        if (q !== expq) begin
            errors++;
            $display("FAIL %s_quotient: got %h want %h", name, q, expq);
        end
        checks++;
        if ({dut.DM1.Core[0], dut.DM1.Core[1], dut.DM1.Core[2]} !== {dvd, dvs}) begin
            errors++;
            $display("FAIL %s_operands: got %h want %h", name,
                     {dut.DM1.Core[0], dut.DM1.Core[1], dut.DM1.Core[2]}, {dvd, dvs});
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b want 0", Ack);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.RF1.Registers[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 00", i, dut.RF1.Registers[i]);
            end
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (Ack !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL no_spurious_launch: ack %b state %0d want 0/IDLE", Ack, dut.state_q);
        end
    endtask

    task automatic test_basic();
        run_div(16'd385, 8'd6, 24'h00402A, 30, "div385_6");
    endtask

    task automatic test_vectors();
        run_div(16'd3, 8'd255, 24'h000003, 30, "div3_255");
        run_div(16'hFFFF, 8'd255, 24'h010100, 30, "div65535_255");
        run_div(16'hFFFF, 8'd1, 24'hFFFF00, 30, "div65535_1");
        run_div(16'd0, 8'd7, 24'h000000, 30, "div0_7");
        run_div(16'd1, 8'd0, 24'hFFFFFF, 7, "div1_0");
    endtask

    task automatic test_ack_hold();
        logic [23:0] q;
        run_div(16'd385, 8'd6, 24'h00402A, 30, "hold");
        q = {dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]};
        repeat (40) @(negedge Clk);
        checks++;
        if (Ack !== 1'b1 || dut.state_q !== DONE) begin
            errors++;
            $display("FAIL ack_hold: ack %b state %0d want 1/DONE", Ack, dut.state_q);
        end
        checks++;
        if ({dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]} !== q) begin
            errors++;
            $display("FAIL result_stable: got %h want %h",
                     {dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]}, q);
        end
        Start = 1'b1;
        @(negedge Clk);
        checks++;
        if (Ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear_on_start: got %b want 0", Ack);
        end
        Start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        arm_and_load(16'd385, 8'd6);
        repeat (14) @(negedge Clk);
        checks++;
        if (dut.state_q !== DIV) begin
            errors++;
            $display("FAIL mid_state_div: got %0d want %0d", dut.state_q, DIV);
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (Ack !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_mid: ack %b state %0d want 0/IDLE", Ack, dut.state_q);
        end
        Reset = 1'b0;
        run_div(16'd385, 8'd6, 24'h00402A, 30, "after_reset");
    endtask

    task automatic test_start_mid();
        arm_and_load(16'hFFFF, 8'd1);
        repeat (10) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        checks++;
        if (dut.state_q !== IDLE || Ack !== 1'b0) begin
            errors++;
            $display("FAIL start_abort: state %0d ack %b want IDLE/0", dut.state_q, Ack);
        end
        run_div(16'd100, 8'd3, 24'h002155, 30, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_div(16'd385, 8'd6, 24'h00402A, 30, "b2b_first");
        run_div(16'd100, 8'd3, 24'h002155, 30, "b2b_second");
        checks++;
        if (dut.RF1.Registers[6] !== 8'h00 || dut.RF1.Registers[7] !== 8'h00) begin
            errors++;
            $display("FAIL unused_regs: got %h %h want 00 00",
                     dut.RF1.Registers[6], dut.RF1.Registers[7]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        Start  = 1'b0;
        test_reset();
        test_basic();
        test_vectors();
        test_ack_hold();
        test_reset_mid();
        test_start_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Top-level compute engine for Program 2: fixed-point division of a 16-bit unsigned dividend by an 8-bit unsigned divisor, giving a 24-bit quotient (16 integer bits, 8 fractional bits, truncated).
- Operands and result live in an internal byte-wide data memory; a hardwired sequencer steps a restoring divider through an 8x8 register file.
- Started by a Start pulse; completion signalled on Ack.

Parameters:
- DM_DEPTH, 256, data memory bytes.
- RF_DEPTH, 8, register file entries (8-bit each).
- QBITS, 24, quotient width / divide iterations.

Ports:
- Clk  input  1  system clock, all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  launch request: high = hold/arm, first cycle low after high = run.
- Ack  output  1  program complete; held high until next Start or Reset.

Behaviour:
- Hierarchy for bench access is mandatory:
  - Instance DM1 has array Core[0:255] of 8-bit words; async read, sync write.
  - Instance RF1 has array Registers[0:7] of 8-bit words.
- Memory map: Core[0] = dividend[15:8], Core[1] = dividend[7:0], Core[2] = divisor, Core[4..6] = quotient[23:16], [15:8], [7:0].
- Core[3] and Core[7..255] are never written.
- Reset (sync): state=IDLE, Ack=0, Registers cleared. DM1 contents are NOT reset, so the bench may preload during or after reset.
- Start=1 in any state: go to IDLE, Ack=0, no memory writes. Bench may preload Core[0..2] freely while Start is high.
- Launch: on the first rising edge with Start=0 while armed (Start was high on the previous edge), go IDLE->LD0. Start held low after completion does not relaunch.
- States:
  - LD0: R0 <= Core[0].
  - LD1: R1 <= Core[1].
  - LD2: R4 <= Core[2]; R3 <= 0; R5 <= 24 (iteration count). If Core[2]==0, go to ZERO, else DIV.
  - DIV (24 cycles): numerator {R0,R1,8'h00} shifted MSB-first into the 9-bit partial remainder {c,R3}.
    - Per cycle: rem = {R3,nextbit}. If rem >= R4, then rem -= R4 and the quotient bit is 1; otherwise the bit is 0.
    - Quotient bits shift into {R0,R1,R2}, which double as the numerator shifter. R5 decrements; leave when R5 reaches 1.
  - ZERO: {R0,R1,R2} <= 24'hFFFFFF (saturate).
  - ST4, ST5, ST6: write R0, R1, R2 to Core[4], Core[5], Core[6], one per cycle.
  - DONE: Ack=1; stay until Start=1 or Reset.
- Result = floor(dividend*256/divisor) for divisor != 0. Always fits in 24 bits; no rounding.
- Latency: Ack rises 30 cycles after the launch edge (3 load + 24 divide + 3 store), or 7 cycles when divisor=0.
- Core[4..6] are valid when Ack rises and stay stable while Ack is high.
- Reset mid-run: abort immediately, Ack=0. Partially written Core[4..6] is permitted; the next launch rewrites them fully.
- Start=1 mid-run: abort to IDLE; rearm follows the launch rule.
- R6 and R7 are unused and stay 0.

Decomposition:
- Shared package cpu_pkg:
  - State enum (IDLE, LD0, LD1, LD2, DIV, ZERO, ST4, ST5, ST6, DONE).
  - Memory address constants ADDR_DVD_HI=0, ADDR_DVD_LO=1, ADDR_DVS=2, ADDR_Q2=4, ADDR_Q1=5, ADDR_Q0=6.
  - Register index constants.
- Sub-modules:
  - data_mem (instance DM1).
  - reg_file (instance RF1; 1 write port, async reads).
  - Sequencer and divide datapath stay in cpu.

Test Plan:
- Core[0..2]=0x01,0x81,0x06 (385/6), Reset pulse, Start high 2 cycles then low -> Ack after 30 cycles; Core[4..6]=0x00,0x40,0x2A.
- 3/255 -> 0x000003; 65535/255 -> 0x010100; 65535/1 -> 0xFFFF00; 0/7 -> 0x000000.
- 1/0 -> Core[4..6]=0xFF,0xFF,0xFF, Ack 7 cycles after launch.
- Ack stays 0 throughout reset and Start-high period and until completion. Ack stays high while Start low; dropping Start to 1 clears Ack next edge.
- Reset asserted at divide cycle 10 -> Ack=0, state IDLE. Relaunch with 385/6 -> correct 0x00402A.
- Back-to-back runs: 385/6 then reload 100/3 and relaunch -> 0x002155, Core[0..2] unchanged by the CPU.
